// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle core controller.
// Optional trap state is built when CORE_CTRL_TRAP_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
`ifdef CORE_CTRL_TRAP_EN
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_e;

  localparam logic [1:0] PC_P4   = 2'b00;
  localparam logic [1:0] PC_JALR = 2'b01;
  localparam logic [1:0] PC_ADD  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_LD  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic A_RS1 = 1'b0;
  localparam logic A_PC  = 1'b1;
  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  typedef struct packed {
    logic branch;
    logic jal;
    logic jalr;
    logic load;
    logic store;
    logic op;
    logic opimm;
    logic lui;
    logic auipc;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier for the core controller.
// One-hot class flags; anything unlisted is illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_BRANCH: dec.branch  = 1'b1;
      OP_JAL:    dec.jal     = 1'b1;
      OP_JALR:   dec.jalr    = 1'b1;
      OP_LOAD:   dec.load    = 1'b1;
      OP_STORE:  dec.store   = 1'b1;
      OP_OP:     dec.op      = 1'b1;
      OP_OPIMM:  dec.opimm   = 1'b1;
      OP_LUI:    dec.lui     = 1'b1;
      OP_AUIPC:  dec.auipc   = 1'b1;
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control FSM with retired-instruction counter.
// CORE_CTRL_TRAP_EN: illegal opcodes lock in TRAP until reset.
module core_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 br_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 a_sel,
  output logic                 b_sel,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  dec_t   dec;
  state_e cur, nxt;
  logic   retire;
  logic   ir_c, pc_c, req_c, we_c, rf_c;

  ctrl_decode u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    nxt     = cur;
    retire  = 1'b0;
    ir_c    = 1'b0;
    pc_c    = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    rf_c    = 1'b0;
    pc_sel  = PC_P4;
    a_sel   = A_RS1;
    b_sel   = B_RS2;
    wb_sel  = WB_ALU;
    illegal = 1'b0;
    unique case (cur)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_c = 1'b1;
          nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
`ifdef CORE_CTRL_TRAP_EN
          nxt = S_TRAP;
`else
          illegal = 1'b1;
          pc_c    = 1'b1;
          nxt     = S_FETCH;
`endif
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          dec.branch: begin
            pc_c   = 1'b1;
            pc_sel = br_taken ? PC_ADD : PC_P4;
            retire = 1'b1;
            nxt    = S_FETCH;
          end
          dec.jal, dec.jalr: begin
            b_sel  = dec.jalr ? B_IMM : B_RS2;
            pc_sel = dec.jalr ? PC_JALR : PC_ADD;
            pc_c   = 1'b1;
            rf_c   = 1'b1;
            wb_sel = WB_PC4;
            retire = 1'b1;
            nxt    = S_FETCH;
          end
          dec.load, dec.store: begin
            b_sel = B_IMM;
            nxt   = S_MEM;
          end
          dec.op: nxt = S_WB;
          dec.opimm, dec.lui: begin
            b_sel = B_IMM;
            nxt   = S_WB;
          end
          dec.auipc: begin
            a_sel = A_PC;
            b_sel = B_IMM;
            nxt   = S_WB;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        b_sel = B_IMM;
        req_c = 1'b1;
        we_c  = dec.store;
        if (mem_ready) begin
          if (dec.store) begin
            pc_c   = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_c   = 1'b1;
        wb_sel = dec.load ? WB_LD : WB_ALU;
        pc_c   = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
`ifdef CORE_CTRL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: nxt = S_FETCH;
    endcase
  end

  // a reset cycle must never launch a memory access or register update
  assign ir_we   = ir_c  & ~rst;
  assign pc_we   = pc_c  & ~rst;
  assign mem_req = req_c & ~rst;
  assign mem_we  = we_c  & ~rst;
  assign rf_we   = rf_c  & ~rst;
  assign state   = cur;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed cases plus random
// instruction stream against a per-class expected-behaviour model.
module tb_core_ctrl;
  import ctrl_pkg::*;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready, br_taken;
  logic          ir_we, pc_we, a_sel, b_sel;
  logic          mem_req, mem_we, rf_we, illegal;
  logic [1:0]    pc_sel, wb_sel;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  localparam int C_BR = 0, C_JAL = 1, C_JALR = 2, C_LD = 3;
  localparam int C_ST = 4, C_OP = 5, C_OPI = 6, C_LUI = 7;
  localparam int C_AUI = 8;

  core_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .a_sel(a_sel), .b_sel(b_sel), .mem_req(mem_req),
    .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input int c);
    case (c)
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LD:    return 7'b0000011;
      C_ST:    return 7'b0100011;
      C_OP:    return 7'b0110011;
      C_OPI:   return 7'b0010011;
      C_LUI:   return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  // fetch with fw wait cycles; IR takes new opcode after accept edge
  task automatic fetch(input int fw, input logic [6:0] op);
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      opcode    = 7'($urandom);
      #1;
      chk("fetch_state", state, 32'(S_FETCH));
      chk("fetch_req", mem_req, 1);
      chk("fetch_we", mem_we, 0);
      chk("fetch_ir_we", ir_we, (i == fw));
      tick();
    end
    opcode = op;
  endtask

  task automatic run_instr(input int c, input int fw,
                           input int mw, input logic brt);
    state_e q[$];
    int n, mi, lat;
    logic done, in_mem, jump, st;
    jump = (c == C_BR) || (c == C_JAL) || (c == C_JALR);
    st   = (c == C_ST);
    q.push_back(S_DECODE);
    q.push_back(S_EXEC);
    if (c == C_LD || st)
      for (int i = 0; i <= mw; i++) q.push_back(S_MEM);
    if (!jump && !st) q.push_back(S_WB);
    lat = jump ? 3 : (c == C_LD) ? 5 + mw : st ? 4 + mw : 4;
    br_taken = brt;
    fetch(fw, op_of(c));
    n = 0; mi = 0; done = 1'b0;
    while (!done && n < 12) begin
      in_mem = (n < q.size()) && (q[n] == S_MEM);
      mem_ready = in_mem ? (mi == mw) : 1'($urandom);
      #1;
      if (n < q.size()) chk("state", state, 32'(q[n]));
      else chk("overrun", n, q.size() - 1);
      chk("mem_req", mem_req, in_mem);
      chk("ir_we", ir_we, 0);
      chk("illegal", illegal, 0);
      if (in_mem) begin
        chk("mem_we", mem_we, st);
        chk("mem_asel", a_sel, 0);
        chk("mem_bsel", b_sel, 1);
        mi++;
      end
      if (n == 1) begin
        chk("exec_asel", a_sel, (c == C_AUI));
        chk("exec_bsel", b_sel,
            !(c == C_BR || c == C_OP || c == C_JAL));
      end
      if (pc_we) begin
        done = 1'b1;
        chk("pc_sel", pc_sel,
            (c == C_JAL || (c == C_BR && brt)) ? 2 :
            (c == C_JALR) ? 1 : 0);
        chk("rf_we", rf_we, !(c == C_BR || st));
        if (!(c == C_BR || st))
          chk("wb_sel", wb_sel,
              (c == C_JAL || c == C_JALR) ? 2 :
              (c == C_LD) ? 1 : 0);
      end else begin
        chk("rf_we_idle", rf_we, 0);
      end
      n++;
      tick();
    end
    chk("latency", n + 1, lat);
    exp_cnt = (exp_cnt + 1) % (1 << IW);
    chk("instret", instret, exp_cnt);
  endtask

  task automatic run_rand();
    run_instr($urandom_range(0, 8), $urandom_range(0, 2),
              $urandom_range(0, 2), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0; br_taken = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    tick();
    chk("rst_req2", mem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    rst = 1'b0;
    #1;
    chk("rst_state", state, 32'(S_FETCH));
    chk("rst_instret", instret, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_sels", {a_sel, b_sel, pc_sel, wb_sel}, 0);

    run_instr(C_OPI, 0, 0, 1'b0);
    run_instr(C_LD, 0, 3, 1'b0);
    run_instr(C_BR, 0, 0, 1'b1);
    run_instr(C_BR, 1, 0, 1'b0);
    run_instr(C_ST, 0, 1, 1'b0);
    run_instr(C_JAL, 0, 0, 1'b0);
    run_instr(C_JALR, 2, 0, 1'b0);
    run_instr(C_AUI, 0, 0, 1'b0);

    // illegal opcode
    fetch(0, 7'b1111111);
    mem_ready = 1'b1;
    #1;
    chk("ill_dec_state", state, 32'(S_DECODE));
`ifdef CORE_CTRL_TRAP_EN
    chk("ill_dec_pc_we", pc_we, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("trap_state", state, 32'(S_TRAP));
      chk("trap_illegal", illegal, 1);
      chk("trap_strobes", {ir_we, pc_we, mem_req, rf_we}, 0);
      tick();
    end
    chk("trap_instret", instret, exp_cnt);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    chk("trap_clear", illegal, 0);
`else
    chk("ill_pulse", illegal, 1);
    chk("ill_pc_we", pc_we, 1);
    chk("ill_pc_sel", pc_sel, 0);
    chk("ill_rf_we", rf_we, 0);
    tick();
    chk("ill_next", state, 32'(S_FETCH));
    chk("ill_drop", illegal, 0);
    chk("ill_instret", instret, exp_cnt);
`endif

    for (int i = 0; i < 25; i++) run_rand();

    // reset in the middle of a store's memory access
    br_taken = 1'b0;
    fetch(0, op_of(C_ST));
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_mem_state", state, 32'(S_MEM));
    chk("mid_mem_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    chk("rst_mem_state", state, 32'(S_FETCH));
    chk("rst_mem_instret", instret, 0);

    for (int i = 0; i < (1 << IW) - 1; i++) run_rand();
    chk("instret_ones", instret, (1 << IW) - 1);
    run_instr(C_OP, 0, 0, 1'b0);
    chk("instret_wrap", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
